// File: rtl/uart_pkg.sv
// Shared UART package: bit-rate defaults and state encodings used by both the
// transmit and receive paths. The optional parity slot (UART_TX_PARITY_EN)
// keeps its encoding here so TX and RX agree even when it is compiled out.
package uart_pkg;

  localparam int CLOCK_FREQ = 60000000;
  localparam int BAUD_RATE  = 9600;
  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver. Counts
// 0..BIT_PERIOD-1 and raises tick on the last cycle of each bit; clear holds
// the count at zero so the first bit after an idle gap is full length.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int PERIOD = uart_pkg::BIT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  logic [15:0] count_reg;

  assign tick = (count_reg == LAST);

  // Period counter: wraps at each bit boundary, held at zero while cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: ready/valid byte input, 8N1 serial output, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
// The line output is registered so tx never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = uart_pkg::CLOCK_FREQ,
  parameter int BAUD_RATE  = uart_pkg::BAUD_RATE,
  parameter int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  uart_state_e state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        tx_reg, tx_next;
  logic        done_reg, done_next;
  logic        timer_clear;
  logic        tick;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  uart_bit_timer #(.PERIOD(BIT_PERIOD)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  assign bus.tx_ready = (state_reg == IDLE);
  assign accept       = bus.tx_valid && (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign tx           = tx_reg;
  assign done         = done_reg;

  // State, counters, shift register and registered line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  // Next-state logic; tx_next is the line level for the state being entered.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    done_next    = 1'b0;
    timer_clear  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        timer_clear = 1'b1;
        tx_next     = 1'b1;
        if (accept) begin
          state_next   = START_BIT;
          shift_next   = bus.tx_byte;
          bit_cnt_next = 3'd0;
          tx_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^bus.tx_byte;
`endif
        end
      end
      START_BIT: begin
        if (tick) begin
          state_next = DATA_BITS;
          tx_next    = shift_reg[0];
        end
      end
      DATA_BITS: begin
        if (tick) begin
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY_BIT;
            tx_next      = parity_reg;
`else
            state_next   = STOP_BIT;
            tx_next      = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: begin
        if (tick) begin
          state_next = STOP_BIT;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP_BIT: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with P = 16 clocks per bit. The expected line level
// for every cycle of a frame is derived from the frame layout (start, data
// LSB first, optional even parity, stop) and the accept cycle.
module tb_uart_tx;
  localparam int CF = 160;
  localparam int BR = 10;
  localparam int P  = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * P;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx, busy, done;
  int   errors = 0;
  int   checks = 0;

  uart_tx_if bus ();

  uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line level k cycles after the start of a frame carrying byte b.
  function automatic logic ref_bit(input logic [7:0] b, input int k);
    int slot;
    slot = k / P;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called just after the accept edge; checks the whole frame and the done cycle.
  task automatic check_frame(input logic [7:0] b, input bit noise, input bit chain,
                             input logic [7:0] next_b);
    int e0;
    e0 = errors;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d] byte %h", k, b), tx, ref_bit(b, k));
      chk("busy_high", busy, 1);
      chk("done_low", done, 0);
      chk("ready_low", bus.tx_ready, 0);
      if (noise) begin
        bus.tx_valid = 1'($urandom_range(0, 1));
        bus.tx_byte  = 8'($urandom);
      end else if (chain) begin
        bus.tx_valid = 1'b1;
        bus.tx_byte  = next_b;
      end else begin
        bus.tx_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("ready_at_end", bus.tx_ready, 1);
    chk("tx_idle_at_end", tx, 1);
    chk("busy_at_end", busy, 0);
    bus.tx_valid = chain;
    bus.tx_byte  = next_b;
    $display("frame byte=%h noise=%0d chain=%0d new_errors=%0d", b, noise, chain, errors - e0);
  endtask

  task automatic send(input logic [7:0] b, input bit noise);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_byte  = b;
    @(posedge clk);
    check_frame(b, noise, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    bus.tx_valid = 1'b0;
    bus.tx_byte  = 8'h00;

    // Reset held, then released with tx_valid low: idle for 100 cycles.
    repeat (3) @(negedge clk);
    chk("tx_in_reset", tx, 1);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", bus.tx_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
    $display("reset idle window checked errors=%0d", errors);

    // Known pattern.
    send(8'hA5, 1'b0);

    // Back-to-back with tx_valid held high: 00 then FF.
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_byte  = 8'h00;
    @(posedge clk);
    check_frame(8'h00, 1'b0, 1'b1, 8'hFF);
    @(posedge clk);
    check_frame(8'hFF, 1'b0, 1'b0, 8'h00);

    // Inputs toggled during the frame must be ignored.
    send(8'h3C, 1'b1);

    // Randomized bytes.
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);

    // Reset at A+50 while a data bit of 0 is on the line.
    b = 8'($urandom) & 8'hFB;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_byte  = b;
    @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) bus.tx_valid = 1'b0;
    end
    chk("tx_before_reset", tx, ref_bit(b, 49));
    #1 reset = 1'b1;
    #1;
    chk("tx_async_reset", tx, 1);
    chk("busy_async_reset", busy, 0);
    chk("ready_async_reset", bus.tx_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_done", done, 0);
      chk("post_reset_tx", tx, 1);
    end
    $display("mid-frame reset byte=%h errors=%0d", b, errors);
    send(8'h81, 1'b0);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b0);
    send(8'h03, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter for the DCT UART link. Accepts bytes over a ready/valid handshake and serialises each one onto `tx` as 8N1 frames, LSB first: one start bit, eight data bits, an optional even-parity bit, and one stop bit. It is the transmit-side counterpart of the receive path and shares its bit-rate constants, so both ends of the link run at the same baud. It sits between the byte producer, such as the DCT result formatter, and the board TX pin.

## Interface
Parameters:
- `CLOCK_FREQ`, 60000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `BIT_PERIOD`, `CLOCK_FREQ/BAUD_RATE` (6250): clocks per bit. Integer division is used; the value must lie between 2 and 65535.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_byte`  in  8  byte to send; sampled only in the accept cycle.
- `tx_valid`  in  1  producer has a byte on `tx_byte`.
- `tx_ready`  out  1  block can accept a byte this cycle.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `done`=0; state=IDLE; bit counter=0; period counter=0; shift register=0.
- A byte is accepted in any cycle where `tx_valid && tx_ready` is true. In that cycle `tx_byte` is latched into the shift register, and `tx_ready` drops and `busy` rises from the next cycle on.
- Changes to `tx_byte` or `tx_valid` while `busy` is high are ignored. `tx_valid` asserted while `tx_ready` is low is not an accept.
- State machine:
  - IDLE → START_BIT on accept.
  - START_BIT → DATA_BITS after BIT_PERIOD cycles.
  - DATA_BITS → STOP_BIT after 8×BIT_PERIOD cycles, or → PARITY_BIT when parity is compiled in.
  - PARITY_BIT → STOP_BIT after BIT_PERIOD cycles.
  - STOP_BIT → IDLE after BIT_PERIOD cycles.
  - Any unused encoding → IDLE with `tx`=1.
- `tx` values per state: START_BIT drives 0. DATA_BITS drives shift register bit 0, and the register shifts right once per bit. PARITY_BIT drives the XOR of the latched byte. STOP_BIT and IDLE drive 1.
- `tx` is registered and never glitches.
- Period counter: 16 bits, counts 0..BIT_PERIOD−1 and wraps to 0 at each bit boundary.
- Bit counter: 3 bits; it wraps from 7 to 0 on exit from DATA_BITS.
- `done` and `tx_ready` both assert in the cycle the machine re-enters IDLE.
- Back-to-back bytes: a byte offered in that same cycle is accepted immediately.
- Reset mid-frame: `tx` returns to 1 asynchronously, the frame is abandoned with no `done` pulse, and the next accept starts a fresh frame.

## Timing
- Let A be the accept cycle and P be BIT_PERIOD.
- Start bit: `tx`=0 during cycles A+1 .. A+P.
- Data bit i (0..7): `tx` holds bit i during cycles A+1+(i+1)P .. A+(i+2)P.
- Stop bit: `tx`=1 during cycles A+1+9P .. A+10P.
- `done`=1 and `tx_ready`=1 in cycle A+1+10P.
- Frame length on the line is 10P cycles, plus one idle cycle before the next start bit when bytes are streamed back to back.
- With parity compiled in, the parity bit occupies the slot at A+1+9P, and the stop, `done` and `tx_ready` times each move P cycles later.
- Accept-to-line latency is 1 cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY_BIT state present. Even parity (XOR of the 8 data bits) is sent after bit 7; frame is 11P cycles.
- `UART_TX_PARITY_EN` undefined: no PARITY_BIT state and no parity logic; frame is 10P cycles (8N1).

## Structure
- Shared package `uart_pkg` holds:
  - `CLOCK_FREQ`, `BAUD_RATE` and `BIT_PERIOD` defaults, used by both TX and RX.
  - The state encodings IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- One sub-module, `uart_bit_timer`:
  - Contains the period counter with a `clear` input and a `tick` output that pulses on the last cycle of each bit.
  - The same timer is reusable by the receiver.

## Test plan
Bench settings: CLOCK_FREQ=160, BAUD_RATE=10, so P=16.
- Reset release with `tx_valid`=0 → `tx`=1, `tx_ready`=1, `busy`=0, `done`=0 held for 100 cycles.
- Send 8'hA5 → `tx` reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 16 cycles; `done` pulses once in cycle A+161.
- Hold `tx_valid`=1 with 8'h00 then 8'hFF → the second start bit begins in cycle A+162; no byte is dropped or duplicated.
- Toggle `tx_byte` and `tx_valid` during a frame of 8'h3C → the line still carries 8'h3C, and only one `done` pulse occurs.
- Assert `reset` at cycle A+50 → `tx`=1 immediately, no `done` pulse; a following send of 8'h81 is correct.
- Send 8'h07 with `UART_TX_PARITY_EN` defined → parity bit=1 and frame is 176 cycles. Send 8'h03 → parity bit=0.
